monhit_tot_tdc: RTL and testbench

MONHIT_TOT_TDC -- requirements
Module: monhit_tot_tdc

---
 rtl/tdc_pkg.sv | 26 ++
 rtl/monhit_sync.sv | 32 +++
 rtl/monhit_tot_tdc.sv | 148 ++++++++++++++
 tb/tb_monhit_tot_tdc.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// rtl/tdc_pkg.sv - shared constants and state encoding for the MONHIT ToT TDC
// State OUT_TS exists only when MONHIT_TDC_TIMESTAMP_EN is defined.
package tdc_pkg;

  localparam int HDR_W   = 4;
  localparam int TOT_W   = 12;
  localparam int EVENT_W = 16;
  localparam int TS_W    = 28;
  localparam int WORD_W  = HDR_W + EVENT_W + TOT_W;

  localparam logic [HDR_W-1:0] TOT_HEADER_DEF = 4'h4;
  localparam logic [HDR_W-1:0] TS_HEADER_DEF  = 4'h5;

  localparam logic [TOT_W-1:0] TOT_MAX  = {TOT_W{1'b1}};
  localparam logic [7:0]       MISS_MAX = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HIGH    = 2'd1,
`ifdef MONHIT_TDC_TIMESTAMP_EN
    ST_OUT_TS  = 2'd2,
`endif
    ST_OUT_TOT = 2'd3
  } state_t;

endpackage

// File: rtl/monhit_sync.sv
// rtl/monhit_sync.sv - 2-FF synchronizer for the MONHIT pulse with edge detection
// level is the synchronized signal; rise/fall are one-cycle pulses on its edges.
module monhit_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= async_in;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;
  assign fall  = ~sync & prev;

endmodule

// File: rtl/monhit_tot_tdc.sv
// rtl/monhit_tot_tdc.sv - time-over-threshold measurement of MONHIT into 32-bit FIFO words
// Macro MONHIT_TDC_TIMESTAMP_EN adds a timestamp word ahead of every ToT word.
module monhit_tot_tdc
  import tdc_pkg::*;
#(
  parameter logic [HDR_W-1:0] HEADER    = TOT_HEADER_DEF,
  parameter logic [HDR_W-1:0] TS_HEADER = TS_HEADER_DEF
) (
  input  logic              BUS_CLK,
  input  logic              BUS_RST,
  input  logic              MONHIT,
  input  logic              ENABLE,
  output logic [WORD_W-1:0] DATA,
  output logic              DATA_VALID,
  input  logic              DATA_READ,
  output logic [7:0]        MISS_CNT,
  output logic              BUSY
);

  if (HEADER == TS_HEADER) begin : g_header_check
    $error("HEADER and TS_HEADER must differ");
  end

  state_t state, state_next;

  logic               hit_level, hit_rise, hit_fall;
  logic [1:0]         settle_cnt;
  logic               armed;
  logic               start, miss;
  logic [TOT_W-1:0]   tot_cnt;
  logic [EVENT_W-1:0] event_cnt;
  logic [WORD_W-1:0]  data_q;
  logic [7:0]         miss_q;

  monhit_sync u_sync (
    .clk      (BUS_CLK),
    .rst      (BUS_RST),
    .async_in (MONHIT),
    .level    (hit_level),
    .rise     (hit_rise),
    .fall     (hit_fall)
  );

  // Arm only after the synchronizer has settled and seen MONHIT low, so a pulse
  // already high when reset releases never yields a partial ToT.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      settle_cnt <= 2'd0;
      armed      <= 1'b0;
    end else begin
      if (settle_cnt != 2'd2)
        settle_cnt <= settle_cnt + 2'd1;
      if (settle_cnt == 2'd2 && !hit_level)
        armed <= 1'b1;
    end
  end

  assign start = armed && hit_rise && ENABLE && (state == ST_IDLE);
  assign miss  = armed && hit_rise && !start;

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (start) state_next = ST_HIGH;
`ifdef MONHIT_TDC_TIMESTAMP_EN
      ST_HIGH:    if (hit_fall) state_next = ST_OUT_TS;
      ST_OUT_TS:  if (DATA_READ) state_next = ST_OUT_TOT;
`else
      ST_HIGH:    if (hit_fall) state_next = ST_OUT_TOT;
`endif
      ST_OUT_TOT: if (DATA_READ) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    BUSY       = (state != ST_IDLE);
    DATA_VALID = (state == ST_OUT_TOT);
`ifdef MONHIT_TDC_TIMESTAMP_EN
    if (state == ST_OUT_TS)
      DATA_VALID = 1'b1;
`endif
  end

`ifdef MONHIT_TDC_TIMESTAMP_EN
  logic [TS_W-1:0]   ts_cnt;
  logic [TS_W-1:0]   ts_lat;
  logic [WORD_W-1:0] tot_word;

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      ts_cnt   <= '0;
      ts_lat   <= '0;
      tot_word <= '0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
      if (start)
        ts_lat <= ts_cnt;
      if (state == ST_HIGH && hit_fall)
        tot_word <= {HEADER, event_cnt, tot_cnt};
    end
  end
`endif

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      tot_cnt   <= '0;
      event_cnt <= '0;
      miss_q    <= '0;
      data_q    <= '0;
    end else begin
      if (start)
        tot_cnt <= {{(TOT_W-1){1'b0}}, 1'b1};
      else if (state == ST_HIGH && hit_level && tot_cnt != TOT_MAX)
        tot_cnt <= tot_cnt + 1'b1;

      if (miss && miss_q != MISS_MAX)
        miss_q <= miss_q + 8'd1;

      if (state == ST_HIGH && hit_fall) begin
`ifdef MONHIT_TDC_TIMESTAMP_EN
        data_q <= {TS_HEADER, ts_lat};
`else
        data_q <= {HEADER, event_cnt, tot_cnt};
`endif
      end

`ifdef MONHIT_TDC_TIMESTAMP_EN
      if (state == ST_OUT_TS && DATA_READ)
        data_q <= tot_word;
`endif

      if (state == ST_OUT_TOT && DATA_READ)
        event_cnt <= event_cnt + 1'b1;
    end
  end

  assign DATA     = data_q;
  assign MISS_CNT = miss_q;

endmodule

// File: tb/tb_monhit_tot_tdc.sv
// tb/tb_monhit_tot_tdc.sv - directed table-driven bench for monhit_tot_tdc
module tb_monhit_tot_tdc;

  logic        clk = 1'b0;
  logic        rst;
  logic        monhit;
  logic        enable;
  logic [31:0] data;
  logic        data_valid;
  logic        data_read;
  logic [7:0]  miss_cnt;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] words[$];
  int          valid_cycles;

  typedef struct {
    int          len;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[4];

  always #5 clk = ~clk;

  monhit_tot_tdc dut (
    .BUS_CLK    (clk),
    .BUS_RST    (rst),
    .MONHIT     (monhit),
    .ENABLE     (enable),
    .DATA       (data),
    .DATA_VALID (data_valid),
    .DATA_READ  (data_read),
    .MISS_CNT   (miss_cnt),
    .BUSY       (busy)
  );

  always @(negedge clk) begin
    #1;
    if (data_valid) valid_cycles++;
    if (data_valid && data_read && !rst) words.push_back(data);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse(input int len);
    @(negedge clk);
    monhit = 1'b1;
    repeat (len) @(negedge clk);
    monhit = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic check_event(input string name, input logic [31:0] exp);
    logic [31:0] w;
`ifdef MONHIT_TDC_TIMESTAMP_EN
    check({name, "_count"}, words.size(), 2);
    if (words.size() >= 2) begin
      w = words.pop_front();
      check({name, "_ts_hdr"}, {28'd0, w[31:28]}, 32'd5);
      w = words.pop_front();
      check(name, w, exp);
    end
`else
    check({name, "_count"}, words.size(), 1);
    if (words.size() >= 1) begin
      w = words.pop_front();
      check(name, w, exp);
    end
`endif
    words.delete();
  endtask

  localparam int WPE =
`ifdef MONHIT_TDC_TIMESTAMP_EN
    2;
`else
    1;
`endif

  initial begin
    logic [31:0] held;
    vecs[0] = '{7,  32'h4000_0007};
    vecs[1] = '{3,  32'h4000_1003};
    vecs[2] = '{1,  32'h4000_2001};
    vecs[3] = '{20, 32'h4000_3014};

    rst = 1'b1; monhit = 1'b0; enable = 1'b1; data_read = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data", data, 32'h0);
    check("rst_valid", {31'd0, data_valid}, 32'd0);
    check("rst_miss", {24'd0, miss_cnt}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      words.delete();
      valid_cycles = 0;
      pulse(vecs[i].len);
      check_event($sformatf("vec%0d", i), vecs[i].exp);
      check($sformatf("vec%0d_valid_cycles", i), valid_cycles, WPE);
    end

    // consumer stalls; a second pulse arrives while the first word is held
    data_read = 1'b0;
    words.delete();
    pulse(5);
    check("hold_valid", {31'd0, data_valid}, 32'd1);
    held = data;
    @(negedge clk);
    monhit = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 4) monhit = 1'b0;
      if (data !== held || data_valid !== 1'b1) begin
        check("hold_stable", data, held);
        break;
      end
    end
    check("hold_miss", {24'd0, miss_cnt}, 32'd1);
    data_read = 1'b1;
    repeat (8) @(negedge clk);
    check_event("hold_word", 32'h4000_4005);

    pulse(8192);
    check_event("sat_word", 32'h4000_5FFF);

    enable = 1'b0;
    pulse(4);
    check("dis_nowords", words.size(), 0);
    check("dis_miss", {24'd0, miss_cnt}, 32'd2);
    words.delete();

    enable = 1'b1;
    @(negedge clk);
    monhit = 1'b1;
    repeat (4) @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    monhit = 1'b0;
    repeat (8) @(negedge clk);
    check_event("en_drop_word", 32'h4000_6007);
    enable = 1'b1;

    // reset in the middle of a measurement with MONHIT still high
    @(negedge clk);
    monhit = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    words.delete();
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_miss", {24'd0, miss_cnt}, 32'd0);
    repeat (10) @(negedge clk);
    monhit = 1'b0;
    repeat (8) @(negedge clk);
    check("mid_rst_nowords", words.size(), 0);
    check("mid_rst_idle", {31'd0, busy}, 32'd0);
    pulse(3);
    check_event("post_rst_word", 32'h4000_0003);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
